// File: rtl/wormhole_switch_allocator_if.sv
// wormhole_switch_allocator_if
// Groups the request/grant signals of the 5-port wormhole switch allocator.
//   in_val       [NPORTS]        head flit valid per input
//   in_flit_type [2*NPORTS]      {eop,bop} of each input head flit
//   route_req    [NPORTS*NPORTS] one-hot requested output per input
//   out_ready    [NPORTS]        downstream can accept a flit per output
//   in_pop       [NPORTS]        head flit of input transferred this cycle
//   out_val      [NPORTS]        output carries a valid flit this cycle
//   xbar_sel     [NPORTS*SELW]   input index per output, all ones when none
//   out_locked   [NPORTS]        output held by a packet
//   err_orphan, err_multi        sticky protocol error flags
//   wdog_err     [NPORTS]        sticky per output watchdog release flag
// modport master: request side (router datapath / bench); slave: allocator.
interface wormhole_switch_allocator_if #(
    parameter int unsigned NPORTS = 5,
    parameter int unsigned SELW   = 3
);
    logic [NPORTS-1:0]        in_val;
    logic [2*NPORTS-1:0]      in_flit_type;
    logic [NPORTS*NPORTS-1:0] route_req;
    logic [NPORTS-1:0]        out_ready;
    logic [NPORTS-1:0]        in_pop;
    logic [NPORTS-1:0]        out_val;
    logic [NPORTS*SELW-1:0]   xbar_sel;
    logic [NPORTS-1:0]        out_locked;
    logic                     err_orphan;
    logic                     err_multi;
    logic [NPORTS-1:0]        wdog_err;

    modport master (
        output in_val, in_flit_type, route_req, out_ready,
        input  in_pop, out_val, xbar_sel, out_locked, err_orphan, err_multi, wdog_err
    );

    modport slave (
        input  in_val, in_flit_type, route_req, out_ready,
        output in_pop, out_val, xbar_sel, out_locked, err_orphan, err_multi, wdog_err
    );
endinterface

// File: rtl/wormhole_switch_allocator.sv
// wormhole_switch_allocator
// Per-output, packet-granular round-robin switch allocator for the 5-port
// mesh router (port 0 = core, 1-4 = link1-link4). A header winner holds its
// output until the tail flit transfers, so packets never interleave.
// Ports:
//   clk0   router clock, rising edge
//   reset  asynchronous active-low reset
//   bus    wormhole_switch_allocator_if.slave (requests in, grants out)
// Optional feature: define ALLOC_WATCHDOG_EN to release a lock whose owner
// stalls for WDOG_CYCLES cycles (sets the sticky wdog_err bit of that output).
module wormhole_switch_allocator #(
    parameter int unsigned NPORTS      = 5,
    parameter int unsigned SELW        = 3,
    parameter int unsigned WDOG_CYCLES = 255
) (
    input logic                          clk0,
    input logic                          reset,
    wormhole_switch_allocator_if.slave   bus
);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

    state_e            state_q [NPORTS];
    state_e            state_d [NPORTS];
    logic [SELW-1:0]   owner_q [NPORTS];
    logic [SELW-1:0]   owner_d [NPORTS];
    logic [SELW-1:0]   ptr_q   [NPORTS];
    logic [SELW-1:0]   ptr_d   [NPORTS];
    logic              err_orphan_q, err_orphan_d;
    logic              err_multi_q,  err_multi_d;

    logic [NPORTS-1:0] onehot;
    logic [NPORTS-1:0] elig [NPORTS];   // elig[o][i]: input i validly requests output o
    logic [NPORTS-1:0] bop, eop;
    logic [NPORTS-1:0]      in_pop, out_val, out_locked;
    logic [NPORTS*SELW-1:0] xbar_sel;

`ifdef ALLOC_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_cnt_q [NPORTS];
    logic [WDOG_W-1:0] wdog_cnt_d [NPORTS];
    logic [NPORTS-1:0] wdog_err_q, wdog_err_d;
`endif

    // Request decode: a request counts only when its route field is one-hot.
    always_comb begin
        onehot      = '0;
        bop         = '0;
        eop         = '0;
        err_multi_d = err_multi_q;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            bop[i]    = bus.in_flit_type[2*i];
            eop[i]    = bus.in_flit_type[2*i+1];
            onehot[i] = (bus.route_req[i*NPORTS +: NPORTS] != '0) &&
                        ((bus.route_req[i*NPORTS +: NPORTS] &
                          (bus.route_req[i*NPORTS +: NPORTS] - NPORTS'(1))) == '0);
            if (bus.in_val[i] && !onehot[i]) err_multi_d = 1'b1;
        end
        for (int unsigned o = 0; o < NPORTS; o++) begin
            elig[o] = '0;
            for (int unsigned i = 0; i < NPORTS; i++)
                elig[o][i] = bus.in_val[i] && onehot[i] && bus.route_req[i*NPORTS + o];
        end
    end

    // Per-output FSM next state and grant outputs.
    always_comb begin
        logic            found;
        logic [SELW-1:0] win;
        logic [SELW-1:0] own;
        int unsigned     idx;

        state_d      = state_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        err_orphan_d = err_orphan_q;
        in_pop       = '0;
        out_val      = '0;
        xbar_sel     = '1;
`ifdef ALLOC_WATCHDOG_EN
        wdog_cnt_d   = wdog_cnt_q;
        wdog_err_d   = wdog_err_q;
`endif
        for (int unsigned o = 0; o < NPORTS; o++) begin
            found = 1'b0;
            win   = '0;
            own   = owner_q[o];
            idx   = 0;
            case (state_q[o])
                ST_IDLE: begin
                    // Rotating scan from ptr; only headers (bop=1) may win.
                    for (int unsigned k = 0; k < NPORTS; k++) begin
                        idx = 32'(ptr_q[o]) + k;
                        if (idx >= NPORTS) idx = idx - NPORTS;
                        if (!found && elig[o][idx] && bop[idx]) begin
                            found = 1'b1;
                            win   = SELW'(idx);
                        end
                    end
                    for (int unsigned i = 0; i < NPORTS; i++)
                        if (elig[o][i] && !bop[i]) err_orphan_d = 1'b1;
                    if (found) begin
                        xbar_sel[o*SELW +: SELW] = win;
                        if (bus.out_ready[o]) begin
                            in_pop[win] = 1'b1;
                            out_val[o]  = 1'b1;
                            ptr_d[o]    = (win == SELW'(NPORTS-1)) ? '0 : win + SELW'(1);
                            if (!eop[win]) begin
                                state_d[o] = ST_LOCKED;
                                owner_d[o] = win;
                            end
                        end
                    end
`ifdef ALLOC_WATCHDOG_EN
                    wdog_cnt_d[o] = '0;
`endif
                end
                ST_LOCKED: begin
                    xbar_sel[o*SELW +: SELW] = own;
                    if (elig[o][own]) begin
                        if (bop[own]) begin
                            err_orphan_d = 1'b1;
                        end else if (bus.out_ready[o]) begin
                            in_pop[own] = 1'b1;
                            out_val[o]  = 1'b1;
                            if (eop[own]) state_d[o] = ST_IDLE;
                        end
                    end
`ifdef ALLOC_WATCHDOG_EN
                    if (out_val[o]) begin
                        wdog_cnt_d[o] = '0;
                    end else if (wdog_cnt_q[o] == WDOG_W'(WDOG_CYCLES - 1)) begin
                        state_d[o]    = ST_IDLE;
                        ptr_d[o]      = (own == SELW'(NPORTS-1)) ? '0 : own + SELW'(1);
                        wdog_err_d[o] = 1'b1;
                        wdog_cnt_d[o] = '0;
                    end else begin
                        wdog_cnt_d[o] = wdog_cnt_q[o] + WDOG_W'(1);
                    end
`endif
                end
            endcase
        end
        // Combinational grants are forced idle while reset is held.
        if (!reset) begin
            in_pop   = '0;
            out_val  = '0;
            xbar_sel = '1;
        end
    end

    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            for (int unsigned o = 0; o < NPORTS; o++) begin
                state_q[o] <= ST_IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
`ifdef ALLOC_WATCHDOG_EN
                wdog_cnt_q[o] <= '0;
`endif
            end
            err_orphan_q <= 1'b0;
            err_multi_q  <= 1'b0;
`ifdef ALLOC_WATCHDOG_EN
            wdog_err_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            err_orphan_q <= err_orphan_d;
            err_multi_q  <= err_multi_d;
`ifdef ALLOC_WATCHDOG_EN
            wdog_cnt_q   <= wdog_cnt_d;
            wdog_err_q   <= wdog_err_d;
`endif
        end
    end

    always_comb begin
        out_locked = '0;
        for (int unsigned o = 0; o < NPORTS; o++)
            out_locked[o] = (state_q[o] == ST_LOCKED);
    end

    assign bus.in_pop     = in_pop;
    assign bus.out_val    = out_val;
    assign bus.xbar_sel   = xbar_sel;
    assign bus.out_locked = out_locked;
    assign bus.err_orphan = err_orphan_q;
    assign bus.err_multi  = err_multi_q;
`ifdef ALLOC_WATCHDOG_EN
    assign bus.wdog_err   = wdog_err_q;
`else
    // No watchdog: locks persist until the tail; WDOG_CYCLES has no effect.
    localparam logic [NPORTS-1:0] WDOG_NONE = (WDOG_CYCLES > 0) ? '0 : '0;
    assign bus.wdog_err   = WDOG_NONE;
`endif

endmodule

// File: tb/tb_wormhole_switch_allocator.sv
module tb_wormhole_switch_allocator;
    logic clk0 = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    wormhole_switch_allocator_if #(.NPORTS(5), .SELW(3)) bus ();

    wormhole_switch_allocator #(.NPORTS(5), .SELW(3), .WDOG_CYCLES(8)) dut (
        .clk0  (clk0),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk0 = ~clk0;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [1:0] ty(input logic [31:0] w);
        return w[31:30];
    endfunction

    function automatic logic [24:0] rt(input int unsigned i, input int unsigned o);
        logic [24:0] r;
        r = '0;
        r[5*i+o] = 1'b1;
        return r;
    endfunction

    task automatic drive(input logic [4:0] v, input logic [9:0] t,
                         input logic [24:0] r, input logic [4:0] rdy);
        bus.in_val       = v;
        bus.in_flit_type = t;
        bus.route_req    = r;
        bus.out_ready    = rdy;
    endtask

    task automatic tick;
        @(posedge clk0);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle of the output-4 contention sequence: drive, check mid-cycle, advance.
    task automatic step4(input string tag, input logic [4:0] v, input logic [1:0] t1,
                         input logic [1:0] t2, input logic [1:0] t3, input logic [4:0] rdy,
                         input logic [4:0] epop, input logic eval4,
                         input logic [2:0] esel, input logic elock);
        drive(v, {2'b00, t3, t2, t1, 2'b00}, rt(1,4) | rt(2,4) | rt(3,4), rdy);
        #3;
        chk({tag, "_pop"},  32'(bus.in_pop), 32'(epop));
        chk({tag, "_oval"}, 32'(bus.out_val), 32'({eval4, 4'b0000}));
        chk({tag, "_sel4"}, 32'(bus.xbar_sel[14:12]), 32'(esel));
        chk({tag, "_lock4"}, 32'(bus.out_locked[4]), 32'(elock));
        tick();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pop"},    32'(bus.in_pop), 32'h0);
        chk({tag, "_oval"},   32'(bus.out_val), 32'h0);
        chk({tag, "_lock"},   32'(bus.out_locked), 32'h0);
        chk({tag, "_xsel"},   32'(bus.xbar_sel), 32'h7FFF);
        chk({tag, "_orphan"}, 32'(bus.err_orphan), 32'h0);
        chk({tag, "_multi"},  32'(bus.err_multi), 32'h0);
        chk({tag, "_wdog"},   32'(bus.wdog_err), 32'h0);
    endtask

    localparam logic [1:0] HDR = 2'b01, BODY = 2'b00, TAIL = 2'b10;

    initial begin
        reset = 1'b1;
        drive('0, '0, '0, '0);
        #1 reset = 1'b0;
        // Reset held for two cycles with random stimulus.
        for (int c = 0; c < 2; c++) begin
            drive(5'($urandom), 10'($urandom), 25'($urandom), 5'($urandom));
            tick();
            chk_idle("rst");
        end
        reset = 1'b1;
        drive('0, '0, '0, 5'h1F);
        #3;
        chk_idle("rel");
        tick();

        // Four-flit packet from input 0 to output 2.
        drive(5'b00001, {8'h00, ty(32'h52545245)}, rt(0,2), 5'h1F);
        #3;
        chk("p0h_pop", 32'(bus.in_pop), 32'h01);
        chk("p0h_oval", 32'(bus.out_val), 32'h04);
        chk("p0h_sel2", 32'(bus.xbar_sel[8:6]), 32'h0);
        chk("p0h_lock", 32'(bus.out_locked), 32'h00);
        tick();
        drive(5'b00001, {8'h00, ty(32'h22545245)}, rt(0,2), 5'h1F);
        #3;
        chk("p0b1_pop", 32'(bus.in_pop), 32'h01);
        chk("p0b1_lock", 32'(bus.out_locked), 32'h04);
        tick();
        drive(5'b00001, {8'h00, ty(32'h22565245)}, rt(0,2), 5'h1F);
        #3;
        chk("p0b2_pop", 32'(bus.in_pop), 32'h01);
        chk("p0b2_oval", 32'(bus.out_val), 32'h04);
        tick();
        drive(5'b00001, {8'h00, ty(32'h82545245)}, rt(0,2), 5'h1F);
        #3;
        chk("p0t_pop", 32'(bus.in_pop), 32'h01);
        chk("p0t_lock", 32'(bus.out_locked), 32'h04);
        tick();
        drive('0, '0, '0, 5'h1F);
        #3;
        chk("p0_done_lock", 32'(bus.out_locked), 32'h00);
        chk("p0_done_pop", 32'(bus.in_pop), 32'h00);
        tick();

        // Inputs 1,2,3 contend for output 4 (ptr=0); stall mid packet 2.
        step4("c1",  5'b01110, ty(32'h45613215), ty(32'h545678F2), ty(32'h44832167), 5'h1F, 5'b00010, 1'b1, 3'd1, 1'b0);
        step4("c2",  5'b01110, ty(32'h05613215), ty(32'h545678F2), ty(32'h44832167), 5'h1F, 5'b00010, 1'b1, 3'd1, 1'b1);
        step4("c3",  5'b01110, ty(32'h85613215), ty(32'h545678F2), ty(32'h44832167), 5'h1F, 5'b00010, 1'b1, 3'd1, 1'b1);
        step4("c4",  5'b01100, BODY, ty(32'h545678F2), ty(32'h44832167), 5'h1F, 5'b00100, 1'b1, 3'd2, 1'b0);
        step4("c5",  5'b01100, BODY, ty(32'h145678F2), ty(32'h44832167), 5'h0F, 5'b00000, 1'b0, 3'd2, 1'b1);
        step4("c6",  5'b01100, BODY, ty(32'h145678F2), ty(32'h44832167), 5'h0F, 5'b00000, 1'b0, 3'd2, 1'b1);
        step4("c7",  5'b01100, BODY, ty(32'h145678F2), ty(32'h44832167), 5'h0F, 5'b00000, 1'b0, 3'd2, 1'b1);
        step4("c8",  5'b01100, BODY, ty(32'h145678F2), ty(32'h44832167), 5'h1F, 5'b00100, 1'b1, 3'd2, 1'b1);
        step4("c9",  5'b01100, BODY, ty(32'h945678F2), ty(32'h44832167), 5'h1F, 5'b00100, 1'b1, 3'd2, 1'b1);
        step4("c10", 5'b01000, BODY, BODY, ty(32'h44832167), 5'h1F, 5'b01000, 1'b1, 3'd3, 1'b0);
        step4("c11", 5'b01000, BODY, BODY, ty(32'h84832167), 5'h1F, 5'b01000, 1'b1, 3'd3, 1'b1);
        step4("c12", 5'b00000, BODY, BODY, BODY, 5'h1F, 5'b00000, 1'b0, 3'd7, 1'b0);

        // Body flit to idle output 1 is an orphan.
        drive(5'b00001, {8'h00, ty(32'h35613215)}, rt(0,1), 5'h1F);
        #3;
        chk("orph_pop", 32'(bus.in_pop), 32'h00);
        chk("orph_oval", 32'(bus.out_val), 32'h00);
        chk("orph_sel1", 32'(bus.xbar_sel[5:3]), 32'h7);
        chk("orph_pre", 32'(bus.err_orphan), 32'h0);
        tick();
        chk("orph_flag", 32'(bus.err_orphan), 32'h1);

        // Multi-hot route field is ignored.
        drive(5'b00010, {6'h00, HDR, 2'b00}, 25'b00110 << 5, 5'h1F);
        #3;
        chk("multi_pop", 32'(bus.in_pop), 32'h00);
        chk("multi_oval", 32'(bus.out_val), 32'h00);
        chk("multi_pre", 32'(bus.err_multi), 32'h0);
        tick();
        chk("multi_flag", 32'(bus.err_multi), 32'h1);

        // Single-flit packet: one transfer, output stays idle.
        drive(5'b00100, {4'h0, 2'b11, 4'h0}, rt(2,0), 5'h1F);
        #3;
        chk("single_pop", 32'(bus.in_pop), 32'h04);
        chk("single_oval", 32'(bus.out_val), 32'h01);
        chk("single_sel0", 32'(bus.xbar_sel[2:0]), 32'h2);
        tick();
        drive('0, '0, '0, 5'h1F);
        #3;
        chk("single_lock", 32'(bus.out_locked), 32'h00);
        tick();

        // Lock output 3 from input 4, then stall the owner.
        drive(5'b10000, {HDR, 8'h00}, rt(4,3), 5'h1F);
        #3;
        chk("wd_hdr_pop", 32'(bus.in_pop), 32'h10);
        chk("wd_hdr_sel3", 32'(bus.xbar_sel[11:9]), 32'h4);
        tick();
        drive('0, '0, '0, 5'h1F);
`ifdef ALLOC_WATCHDOG_EN
        for (int c = 0; c < 8; c++) begin
            #3;
            chk("wd_held", 32'(bus.out_locked[3]), 32'h1);
            tick();
        end
        chk("wd_release", 32'(bus.out_locked[3]), 32'h0);
        chk("wd_err", 32'(bus.wdog_err), 32'h08);
`else
        for (int c = 0; c < 16; c++) tick();
        chk("wd_persist", 32'(bus.out_locked[3]), 32'h1);
        chk("wd_err_off", 32'(bus.wdog_err), 32'h00);
`endif

        // Asynchronous reset mid-packet drops locks and flags at once.
        reset = 1'b0;
        #1;
        chk_idle("arst");
        tick();
        reset = 1'b1;
        drive(5'b10000, {TAIL, 8'h00}, rt(4,3), 5'h1F);
        #3;
        chk("post_rst_pop", 32'(bus.in_pop), 32'h00);
        chk("post_rst_oval", 32'(bus.out_val), 32'h00);
        tick();
        chk("post_rst_orph", 32'(bus.err_orphan), 32'h1);
        drive('0, '0, '0, 5'h1F);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wormhole_switch_allocator.md
Name: wormhole_switch_allocator

Overview:
- Per-output, packet-granular switch allocator for the 5-port mesh router. Port index 0 is core; indices 1-4 are link1-link4.
- Each input presents a one-hot output request (from route compute) and the {eop,bop} type of its head flit.
- Round-robin arbitration runs per output on header flits. The winner holds the output until its tail flit transfers, so packets never interleave.
- Drives crossbar selects, input pop strobes and output valids.

Parameters:
NPORTS, 5, number of router ports (fixed at 5 for this revision)
SELW, 3, width of one crossbar select field
WDOG_CYCLES, 255, idle-lock timeout (used only with the optional feature)

Ports:
clk0  input  1  router clock, rising edge
reset  input  1  asynchronous, active-low reset
in_val  input  5  head flit valid, one bit per input
in_flit_type  input  10  {eop,bop} of input i head flit at [2i+1:2i]; 01 header, 00 body, 10 tail, 11 single-flit
route_req  input  25  input i requested output, one-hot, at [5i+4:5i]
out_ready  input  5  downstream can accept a flit on output o
in_pop  output  5  input i head flit transferred this cycle
out_val  output  5  output o carries a valid flit this cycle
xbar_sel  output  15  input index driving output o at [3o+2:3o]; 7 when none
out_locked  output  5  output o is held by a packet
err_orphan  output  1  sticky: body/tail flit requested an unlocked output
err_multi  output  1  sticky: route_req field not one-hot while in_val=1
wdog_err  output  5  sticky per output: lock released by watchdog

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - all locks, pointers and sticky flags clear; each pointer = 0.
  - in_pop=0, out_val=0, out_locked=0, xbar_sel=all 7s, err_*=0, wdog_err=0.
  - All outputs are forced to these values while reset is low.
- Input i is eligible for output o when in_val[i]=1 and route_req[5i+o]=1, with exactly one route_req bit set.
  - An in_val input whose field is zero or multi-hot is ignored and sets err_multi at the next edge.
- Per-output FSM, two states:
  - IDLE: arbitrate among eligible inputs whose type has bop=1.
    - Scan from ptr[o] upward, mod 5; the first eligible input wins.
    - Winner w: xbar_sel[o]=w in the same cycle (combinational).
    - Transfer when out_ready[o]=1: in_pop[w]=1 and out_val[o]=1 in that cycle.
    - On the edge: ptr[o] = (w+1) mod 5.
    - Type 01 moves to LOCKED(owner=w); type 11 stays IDLE.
    - If out_ready[o]=0: no transfer, no pointer change, arbitration repeats next cycle.
  - IDLE with an eligible bop=0 flit: that flit is never granted, and err_orphan sets.
  - LOCKED(owner):
    - xbar_sel[o]=owner; out_locked[o]=1.
    - Transfer when in_val[owner], the owner requests o, and out_ready[o]=1.
    - A transfer of type 10 returns the output to IDLE at the edge.
    - Type 00 stays LOCKED.
    - Any other input requesting o is not popped.
    - A header (bop=1) from the owner while LOCKED is a protocol error: no transfer, err_orphan sets.
- Latency:
  - Grant-to-transfer is 0 cycles (same cycle).
  - Lock state is registered.
  - A new packet can win an output the cycle after the tail transfers.
- Each input requests at most one output, so in_pop[i] is at most one-hot per input and needs no cross-output conflict logic.
- Simultaneous headers on all 5 inputs to one output with ptr=0: grant order is 0,1,2,3,4, one whole packet each.
- Reset mid-packet: locks drop immediately. The partial packet's remaining body/tail flits are orphans.

Optional Feature:
- Macro ALLOC_WATCHDOG_EN.
- Defined:
  - Per-output counter, reset 0. It increments each cycle the output is LOCKED with no transfer and clears on any transfer.
  - When the count reaches WDOG_CYCLES, the output returns to IDLE, ptr[o]=(owner+1) mod 5, and wdog_err[o] sets (sticky).
  - Counter width is derived from WDOG_CYCLES.
- Not defined: no counters; wdog_err tied to 0; a lock is held indefinitely.

Test Plan:
- Reset low for 2 cycles with random inputs -> all outputs 0, xbar_sel=15'h7FFF. Release -> still idle with no requests.
- Input 0 sends 0x52545245, 0x22545245, 0x22565245, 0x82545245 to output 2 with out_ready=5'h1F -> 4 consecutive in_pop[0]/out_val[2] pulses. out_locked[2] is 1 from the cycle after the header through the tail cycle, 0 after.
- Inputs 1,2,3 present headers (0x45613215, 0x545678F2, 0x44832167) to output 4 in the same cycle with ptr=0 -> complete packets in order 1,2,3; xbar_sel[14:12] = 1 then 2 then 3; never interleaved.
- out_ready[4]=0 for 3 cycles mid-packet -> in_pop=0 and out_val[4]=0 for those cycles; lock and owner held; resumes on out_ready=1.
- Body 0x35613215 to idle output 1 -> no pop, err_orphan=1. route_req field 5'b00110 -> ignored, err_multi=1. Type-11 flit -> single transfer, output stays IDLE.
- With ALLOC_WATCHDOG_EN and WDOG_CYCLES=8: lock output 3, then stall the owner -> after 8 cycles out_locked[3]=0 and wdog_err[3]=1. Without the macro -> lock persists and wdog_err=0.
